// File: rtl/axi_wr_master.sv
// AXI write manager: one INCR burst per local command, incrementing data
// pattern, response captured and reported with a one-cycle done pulse.
module axi_wr_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 8,
    parameter int LEN_W  = 8,
    parameter int RESP_W = 2
) (
    input  logic                i_ACLK,
    input  logic                i_ARESET,
    input  logic                i_cmd_valid,
    output logic                i_cmd_ready,
    input  logic [ADDR_W-1:0]   i_cmd_addr,
    input  logic [LEN_W-1:0]    i_cmd_len,
    input  logic [ID_W-1:0]     i_cmd_id,
    input  logic [DATA_W-1:0]   i_cmd_data,
    output logic [ADDR_W-1:0]   i_AWADDR,
    output logic                i_AWVALID,
    output logic [LEN_W-1:0]    i_AWLEN,
    output logic [1:0]          i_AWBURST,
    output logic [2:0]          i_AWSIZE,
    output logic [1:0]          i_AWLOCK,
    output logic [2:0]          i_AWPROT,
    output logic [3:0]          i_AWCACHE,
    output logic [ID_W-1:0]     i_AWID,
    input  logic                i_AWREADY,
    output logic [DATA_W-1:0]   i_WDATA,
    output logic [DATA_W/8-1:0] i_WSTRB,
    output logic                i_WLAST,
    output logic [ID_W-1:0]     i_WID,
    output logic                i_WVALID,
    input  logic                i_WREADY,
    input  logic [RESP_W-1:0]   i_BRESP,
    input  logic                i_BVALID,
    input  logic [ID_W-1:0]     i_BID,
    output logic                i_BREADY,
    output logic                i_done,
    output logic [RESP_W-1:0]   i_done_resp,
    output logic                i_done_err
);

    localparam int         STRB_W = DATA_W / 8;
    localparam logic [2:0] SIZE   = 3'($clog2(STRB_W));

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        RESP
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [LEN_W-1:0]    r_len;
    logic [ID_W-1:0]     r_id;
    logic [DATA_W-1:0]   r_data;
    logic [LEN_W-1:0]    r_beat;
    logic                r_awvalid;
    logic                r_wvalid;
    logic                r_bready;
    logic                r_done;
    logic [RESP_W-1:0]   r_done_resp;
    logic                r_done_err;

    logic                w_last;

    assign w_last = (r_beat == r_len);

    always_ff @(posedge i_ACLK) begin
        if (i_ARESET) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_len       <= '0;
            r_id        <= '0;
            r_data      <= '0;
            r_beat      <= '0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_done      <= 1'b0;
            r_done_resp <= '0;
            r_done_err  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_cmd_valid) begin
                        r_addr    <= i_cmd_addr;
                        r_len     <= i_cmd_len;
                        r_id      <= i_cmd_id;
                        r_data    <= i_cmd_data;
                        r_beat    <= '0;
                        r_awvalid <= 1'b1;
                        r_state   <= ADDR;
                    end
                end
                ADDR: begin
                    if (i_AWREADY) begin
                        r_awvalid <= 1'b0;
                        r_wvalid  <= 1'b1;
                        r_state   <= DATA;
                    end
                end
                DATA: begin
                    if (i_WREADY) begin
                        r_beat <= r_beat + LEN_W'(1);
                        if (w_last) begin
                            r_wvalid <= 1'b0;
                            r_bready <= 1'b1;
                            r_state  <= RESP;
                        end
                    end
                end
                RESP: begin
                    // A mismatched BID is reported as an error, not dropped
                    if (i_BVALID) begin
                        r_bready    <= 1'b0;
                        r_done      <= 1'b1;
                        r_done_resp <= i_BRESP;
                        r_done_err  <= (i_BRESP != '0) || (i_BID != r_id);
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign i_cmd_ready = (r_state == IDLE);

    assign i_AWADDR    = r_addr;
    assign i_AWVALID   = r_awvalid;
    assign i_AWLEN     = r_len;
    assign i_AWBURST   = 2'b01;
    assign i_AWSIZE    = SIZE;
    assign i_AWLOCK    = 2'b00;
    assign i_AWPROT    = 3'b000;
    assign i_AWCACHE   = 4'b0000;
    assign i_AWID      = r_id;

    assign i_WDATA     = r_data + DATA_W'(r_beat);
    assign i_WSTRB     = '1;
    assign i_WLAST     = r_wvalid & w_last;
    assign i_WID       = r_id;
    assign i_WVALID    = r_wvalid;

    assign i_BREADY    = r_bready;

    assign i_done      = r_done;
    assign i_done_resp = r_done_resp;
    assign i_done_err  = r_done_err;

endmodule
